// File: rtl/prbs16_checker.sv
// prbs16_checker: self-synchronising checker for the 16-bit Galois LFSR
// pattern (x^16+x^14+x^13+x^11+1, right-shifting). It hunts for LOCK_CNT
// consecutive predicted words, then flywheels through isolated errors. It
// counts mismatches seen while locked and drops back to hunting after
// LOSS_CNT consecutive misses.
// Optional feature: define PRBS_CHK_ZERO_DETECT_EN to flag all-zero samples
// on ZERO_ERR and force them to count as non-matching.
module prbs16_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             CLK,
  input  logic             n_RESET,
  input  logic             EN,
  input  logic [15:0]      D,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic             ERR,
  output logic             SYNC_LOST,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic             ZERO_ERR
);

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] n;
    n     = {1'b0, x[15:1]};
    n[15] = x[0];
    n[13] = x[14] ^ x[0];
    n[12] = x[13] ^ x[0];
    n[10] = x[11] ^ x[0];
    return n;
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  state_t             state_p1, state_nxt;
  logic [15:0]        pred_p1, pred_nxt;
  logic [3:0]         match_cnt_p1, match_nxt, match_inc;
  logic [3:0]         miss_cnt_p1, miss_nxt, miss_inc;
  logic               err_nxt, sync_lost_nxt, zero_nxt, cnt_inc;
  logic [ERR_W-1:0]   cnt_nxt;
  logic               is_zero;
  logic               hit;

`ifdef PRBS_CHK_ZERO_DETECT_EN
  // All-zero is the LFSR lock-up word; it can never be a legitimate match.
  assign is_zero = (D == 16'h0000);
`else
  assign is_zero = 1'b0;
`endif

  assign hit       = (D == pred_p1) && !is_zero;
  assign match_inc = match_cnt_p1 + 4'd1;
  assign miss_inc  = miss_cnt_p1 + 4'd1;

  // Next-state, prediction, counter and pulse decode for the current sample.
  always_comb begin
    state_nxt     = state_p1;
    pred_nxt      = pred_p1;
    match_nxt     = match_cnt_p1;
    miss_nxt      = miss_cnt_p1;
    err_nxt       = 1'b0;
    sync_lost_nxt = 1'b0;
    zero_nxt      = 1'b0;
    cnt_inc       = 1'b0;
    cnt_nxt       = ERR_COUNT;
    if (EN) begin
      zero_nxt = is_zero;
      case (state_p1)
        IDLE: begin
          pred_nxt  = lfsr_step(D);
          match_nxt = '0;
          state_nxt = HUNT;
        end
        HUNT: begin
          pred_nxt = lfsr_step(D);
          if (hit) begin
            if (match_inc == LOCK_LIM) begin
              state_nxt = LOCK;
              match_nxt = '0;
            end else begin
              match_nxt = match_inc;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCK: begin
          if (hit) begin
            miss_nxt = '0;
            pred_nxt = lfsr_step(D);
          end else begin
            err_nxt = 1'b1;
            cnt_inc = 1'b1;
            if (miss_inc == LOSS_LIM) begin
              state_nxt     = HUNT;
              pred_nxt      = lfsr_step(D);
              match_nxt     = '0;
              miss_nxt      = '0;
              sync_lost_nxt = 1'b1;
            end else begin
              // Flywheel: a bad word is not trusted, advance from the prediction.
              miss_nxt = miss_inc;
              pred_nxt = lfsr_step(pred_p1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (CLR_ERR) begin
      cnt_nxt = '0;
    end else if (cnt_inc) begin
      cnt_nxt = sat_inc(ERR_COUNT);
    end
  end

  // Stage p1: state, prediction, counters and all registered outputs.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state_p1     <= IDLE;
      pred_p1      <= '0;
      match_cnt_p1 <= '0;
      miss_cnt_p1  <= '0;
      LOCKED       <= 1'b0;
      ERR          <= 1'b0;
      SYNC_LOST    <= 1'b0;
      ERR_COUNT    <= '0;
      ZERO_ERR     <= 1'b0;
    end else begin
      state_p1     <= state_nxt;
      pred_p1      <= pred_nxt;
      match_cnt_p1 <= match_nxt;
      miss_cnt_p1  <= miss_nxt;
      LOCKED       <= (state_nxt == LOCK);
      ERR          <= err_nxt;
      SYNC_LOST    <= sync_lost_nxt;
      ERR_COUNT    <= cnt_nxt;
      ZERO_ERR     <= zero_nxt;
    end
  end

endmodule
